// File: rtl/spi_lcd_pkg.sv
// spi_lcd_pkg: shared FSM state type, mode constants and width helper for the LCD SPI transmitter
package spi_lcd_pkg;
  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;
  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;
  function automatic int ecnt_w(input int data_w);
    return $clog2(2 * data_w + 1);
  endfunction
endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: half-period counter that ticks every div+1 enabled cycles
module spi_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);
  logic [DIV_W-1:0] cnt;
  assign tick = en & (cnt == div);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (clr | tick) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/spi_lcd_tx.sv
// spi_lcd_tx: parametrised SPI transmitter (width, bit order, divider, CPOL/CPHA) for the LCD pins
module spi_lcd_tx
  import spi_lcd_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DIV_W     = 8,
  parameter bit LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_dc,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_done,
  input  logic [DIV_W-1:0]  div,
  input  logic              cpol,
  input  logic              cpha,
  output logic              sck,
  output logic              mosi,
  output logic              cs_n,
  output logic              dc
);
  localparam int EW = ecnt_w(DATA_W);
  localparam logic [EW-1:0] ELAST = EW'(2 * DATA_W - 1);
  state_t state, nstate;
  logic [EW-1:0] ecnt;
  logic [DATA_W-1:0] sreg;
  logic [DIV_W-1:0] div_l;
  logic cpha_l, tick, accept, present, fin;
  logic sck_d, mosi_d, cs_n_d;
  function automatic logic head(input logic [DATA_W-1:0] x);
    return LSB_FIRST ? x[0] : x[DATA_W-1];
  endfunction
  function automatic logic [DATA_W-1:0] shf(input logic [DATA_W-1:0] x);
    return LSB_FIRST ? x >> 1 : x << 1;
  endfunction
  assign tx_ready = state == IDLE;
  assign accept   = tx_valid & tx_ready;
  assign fin      = (state == TRAIL) & tick;
  // ecnt holds the index of the SCK edge about to happen; even index = leading edge
  assign present  = (state == SHIFT) & tick & (cpha_l ? ~ecnt[0] : ecnt[0] & (ecnt != ELAST));
  spi_clk_div #(.DIV_W(DIV_W)) u_div (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (accept),
    .en   (state != IDLE),
    .div  (div_l),
    .tick (tick)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nstate;
  always_comb begin
    nstate = state;
    case (state)
      IDLE:    nstate = accept ? LEAD : IDLE;
      LEAD:    nstate = tick ? SHIFT : LEAD;
      SHIFT:   nstate = (tick && ecnt == ELAST) ? TRAIL : SHIFT;
      TRAIL:   nstate = tick ? GAP : TRAIL;
      default: nstate = tick ? IDLE : GAP;
    endcase
  end
  always_comb begin
    sck_d  = (state == IDLE) ? cpol : ((state == SHIFT) & tick) ? ~sck : sck;
    mosi_d = accept ? (cpha ? 1'b0 : head(tx_data)) : present ? head(sreg) : fin ? 1'b0 : mosi;
    cs_n_d = accept ? 1'b0 : fin ? 1'b1 : cs_n;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sck     <= 1'b0;
      mosi    <= 1'b0;
      cs_n    <= 1'b1;
      dc      <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      sck     <= sck_d;
      mosi    <= mosi_d;
      cs_n    <= cs_n_d;
      dc      <= accept ? tx_dc : dc;
      tx_done <= fin;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      sreg   <= '0;
      ecnt   <= '0;
      div_l  <= '0;
      cpha_l <= 1'b0;
    end else begin
      sreg   <= accept ? (cpha ? tx_data : shf(tx_data)) : present ? shf(sreg) : sreg;
      ecnt   <= accept ? '0 : ((state == SHIFT) & tick) ? ecnt + 1'b1 : ecnt;
      div_l  <= accept ? div : div_l;
      cpha_l <= accept ? cpha : cpha_l;
    end
endmodule

// File: tb/tb_spi_lcd_tx.sv
// tb_spi_lcd_tx: directed table-driven bench for spi_lcd_tx across widths, bit orders and modes
module tb_spi_lcd_tx;
  import spi_lcd_pkg::*;
  logic clk = 0, rst_n = 0;
  logic [15:0] tx_data = '0;
  logic tx_dc = 0, cpol = 0, cpha = 0;
  logic [7:0] div = '0;
  logic [2:0] valid = '0, rdy, done, sck, mosi, cs_n, dc;
  int nvec = 0, nmis = 0;
  always #5 clk = ~clk;
  spi_lcd_tx #(.DATA_W(8)) u0 (.clk(clk), .rst_n(rst_n), .tx_data(tx_data[7:0]), .tx_dc(tx_dc),
    .tx_valid(valid[0]), .tx_ready(rdy[0]), .tx_done(done[0]), .div(div), .cpol(cpol), .cpha(cpha),
    .sck(sck[0]), .mosi(mosi[0]), .cs_n(cs_n[0]), .dc(dc[0]));
  spi_lcd_tx #(.DATA_W(8), .LSB_FIRST(1)) u1 (.clk(clk), .rst_n(rst_n), .tx_data(tx_data[7:0]), .tx_dc(tx_dc),
    .tx_valid(valid[1]), .tx_ready(rdy[1]), .tx_done(done[1]), .div(div), .cpol(cpol), .cpha(cpha),
    .sck(sck[1]), .mosi(mosi[1]), .cs_n(cs_n[1]), .dc(dc[1]));
  spi_lcd_tx #(.DATA_W(16)) u2 (.clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_dc(tx_dc),
    .tx_valid(valid[2]), .tx_ready(rdy[2]), .tx_done(done[2]), .div(div), .cpol(cpol), .cpha(cpha),
    .sck(sck[2]), .mosi(mosi[2]), .cs_n(cs_n[2]), .dc(dc[2]));
  typedef struct {
    int u; logic [15:0] data; logic dcv; logic [7:0] dv; logic [1:0] mode; bit chg;
    logic [15:0] ew; int efirst, eedges, ehp, edone, erdy;
  } vec_t;
  vec_t vt[5];
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s got %h want %h", n, got, exp);
    end
  endtask
  // Sends one word on instance u; labels count negedges after the accept edge (accept edge = 0)
  task automatic frame(input int u, input logic [15:0] d, input logic dcv, input logic [7:0] dv,
                       input logic [1:0] m, input bit chg, output logic [15:0] w, output int first,
                       output int edges, output int hmin, output int hmax, output int dk, output int nd,
                       output int rk, output bit dcbad, output logic fsck, output logic cs0);
    int last;
    logic ps;
    @(negedge clk);
    tx_data = d; tx_dc = dcv; div = dv; {cpol, cpha} = m; valid[u] = 1;
    w = '0; first = -1; edges = 0; hmin = 9999; hmax = 0; dk = -1; nd = 0; rk = -1;
    dcbad = 0; last = -1; ps = m[1]; cs0 = 1'bx;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (k == 0) begin valid[u] = 0; cs0 = cs_n[u]; end
      if (chg && k == 20) div = 0;
      if (sck[u] !== ps) begin
        edges++;
        if (last >= 0) begin
          if (k - last < hmin) hmin = k - last;
          if (k - last > hmax) hmax = k - last;
        end else first = k;
        last = k;
        if (sck[u] === ~(m[1] ^ m[0])) w = {w[14:0], mosi[u]};
      end
      ps = sck[u];
      if (!cs_n[u] && dc[u] !== dcv) dcbad = 1;
      if (done[u]) begin if (dk < 0) dk = k; nd++; end
      if (k > 0 && rdy[u]) begin rk = k; break; end
    end
    fsck = sck[u];
  endtask
  initial begin
    logic [15:0] w;
    int first, edges, hmin, hmax, dk, nd, rk, n;
    bit dcbad;
    logic fsck, cs0, ps;
    logic [31:0] w2;
    int nacc, ndn, hi, gap;
    bit seen_low;
    vt[0] = '{0, 16'hA5,   1, 1, MODE0, 0, 16'hA5,   4, 16, 2, 36,  38};
    vt[1] = '{0, 16'h3C,   0, 1, MODE3, 0, 16'h3C,   4, 16, 2, 36,  38};
    vt[2] = '{1, 16'h01,   1, 0, MODE0, 0, 16'h80,   2, 16, 1, 18,  19};
    vt[3] = '{2, 16'hBEEF, 1, 3, MODE1, 1, 16'hBEEF, 8, 32, 4, 136, 140};
    vt[4] = '{0, 16'h5A,   0, 2, MODE2, 0, 16'h5A,   6, 16, 3, 54,  57};
    #23;
    chk("rst_ready", {29'd0, rdy}, 32'h7);
    chk("rst_done", {29'd0, done}, 32'h0);
    chk("rst_sck", {29'd0, sck}, 32'h0);
    chk("rst_mosi", {29'd0, mosi}, 32'h0);
    chk("rst_cs_n", {29'd0, cs_n}, 32'h7);
    chk("rst_dc", {29'd0, dc}, 32'h0);
    @(negedge clk); rst_n = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      frame(vt[i].u, vt[i].data, vt[i].dcv, vt[i].dv, vt[i].mode, vt[i].chg,
            w, first, edges, hmin, hmax, dk, nd, rk, dcbad, fsck, cs0);
      chk($sformatf("v%0d_word", i), {16'd0, w}, {16'd0, vt[i].ew});
      chk($sformatf("v%0d_first_edge", i), first, vt[i].efirst);
      chk($sformatf("v%0d_edges", i), edges, vt[i].eedges);
      chk($sformatf("v%0d_hp_min", i), hmin, vt[i].ehp);
      chk($sformatf("v%0d_hp_max", i), hmax, vt[i].ehp);
      chk($sformatf("v%0d_done_at", i), dk, vt[i].edone);
      chk($sformatf("v%0d_done_cnt", i), nd, 1);
      chk($sformatf("v%0d_ready_at", i), rk, vt[i].erdy);
      chk($sformatf("v%0d_dc_bad", i), {31'd0, dcbad}, 0);
      chk($sformatf("v%0d_sck_idle", i), {31'd0, fsck}, {31'd0, vt[i].mode[1]});
      chk($sformatf("v%0d_cs_first", i), {31'd0, cs0}, 0);
      @(negedge clk);
    end
    // reset in the middle of an 0xFF frame, at the 4th SCK edge
    @(negedge clk);
    tx_data = 16'hFF; tx_dc = 1; div = 1; {cpol, cpha} = MODE0; valid[0] = 1;
    n = 0; ps = 0;
    for (int k = 0; k < 100 && n < 4; k++) begin
      @(negedge clk);
      valid[0] = 0;
      if (sck[0] !== ps) n++;
      ps = sck[0];
    end
    chk("mid_edge_count", n, 4);
    chk("mid_mosi_before", {31'd0, mosi[0]}, 1);
    rst_n = 0;
    #1;
    chk("mid_cs_n", {31'd0, cs_n[0]}, 1);
    chk("mid_sck", {31'd0, sck[0]}, 0);
    chk("mid_mosi", {31'd0, mosi[0]}, 0);
    chk("mid_ready", {31'd0, rdy[0]}, 1);
    nd = 0;
    repeat (3) begin @(negedge clk); if (done[0]) nd++; end
    rst_n = 1;
    repeat (6) begin @(negedge clk); if (done[0]) nd++; end
    chk("mid_no_done", nd, 0);
    frame(0, 16'h96, 1, 1, MODE0, 0, w, first, edges, hmin, hmax, dk, nd, rk, dcbad, fsck, cs0);
    chk("after_rst_word", {16'd0, w}, 32'h96);
    chk("after_rst_done", dk, 36);
    chk("after_rst_ready", rk, 38);
    // back-to-back with tx_valid held high
    @(negedge clk);
    tx_data = 16'h11; tx_dc = 1; div = 1; {cpol, cpha} = MODE0; valid[0] = 1;
    nacc = 0; ndn = 0; hi = 0; gap = -1; seen_low = 0; w2 = '0; ps = 0;
    for (int k = 0; k < 300; k++) begin
      if (rdy[0] && valid[0]) nacc++;
      @(negedge clk);
      if (!rdy[0] && nacc == 1) tx_data = 16'h22;
      if (!rdy[0] && nacc == 2) valid[0] = 0;
      if (sck[0] !== ps && sck[0] === 1'b1) w2 = {w2[30:0], mosi[0]};
      ps = sck[0];
      if (done[0]) ndn++;
      if (!cs_n[0]) begin
        if (hi > 0 && gap < 0) gap = hi;
        seen_low = 1;
      end else if (seen_low) hi++;
      if (ndn == 2 && rdy[0]) break;
    end
    chk("b2b_accepts", nacc, 2);
    chk("b2b_done_pulses", ndn, 2);
    chk("b2b_words", w2, 32'h1122);
    chk("b2b_cs_gap", gap, 3);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
